mem_stage_ctrl: RTL and testbench
=================================

Name: mem_stage_ctrl

Overview:
- Memory-stage controller that consumes the EX/MEM latch outputs and drives the datapath/dcache request port (dmemREN/dmemWEN/dmemaddr/dmemstore).
- Holds the pipeline with mem_stall until dhit arrives.
- Implements the LL/SC link register, including invalidation by coherence snoops from the other core.
- Produces load/SC result data for the MEM/WB latch.

Parameters:
- BLK_OFF_BITS, 3, low address bits ignored when comparing the link address against addresses (block granularity).
- WORD_W, 32, datapath word width (matches word_t).

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- nRST  in  1  asynchronous active-low reset.
- ex_valid  in  1  EX/MEM holds a real instruction (not a bubble).
- ex_DRen  in  1  load (LW or LL).
- ex_DWen  in  1  store (SW or SC).
- ex_LL  in  1  instruction is LL (implies ex_DRen).
- ex_SC  in  1  instruction is SC (implies ex_DWen).
- ex_halt  in  1  HALT reached the MEM stage.
- ex_addr  in  WORD_W  effective address (alu_out).
- ex_store  in  WORD_W  store data (rdat2).
- dhit  in  1  cache completed the current request.
- dmemload  in  WORD_W  load data, valid with dhit.
- snoop_inv  in  1  coherence invalidate for snoop_addr.
- snoop_addr  in  WORD_W  invalidated address.
- dmemREN  out  1  read request.
- dmemWEN  out  1  write request.
- dmemaddr  out  WORD_W  request address.
- dmemstore  out  WORD_W  write data.
- mem_stall  out  1  freeze IF..EX/MEM this cycle.
- mem_rdata  out  WORD_W  load data or SC result (0/1) for MEM/WB.
- halt_o  out  1  sticky halt to the cache flush logic.

Behaviour:
- Reset (nRST=0, async):
  - state=IDLE, link_valid=0, link_addr=0, rdata_q=0, halt_o=0.
  - All outputs 0.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - Let mem_op = ex_valid & (ex_DRen | ex_DWen).
  - mem_op=0: mem_stall=0; instruction passes through in 1 cycle.
  - mem_op=1: mem_stall=1; next state is ACCESS.
  - Exception: an SC that fails the link check goes directly to DONE with rdata_q=0; it issues no request.
- ACCESS:
  - dmemREN=ex_DRen and dmemWEN=ex_DWen, held stable; dmemaddr=ex_addr; dmemstore=ex_store; mem_stall=1.
  - On dhit: capture rdata_q (dmemload for loads, 1 for SC) and go to DONE.
  - Without dhit: stay in ACCESS indefinitely; no timeout.
- DONE:
  - Requests 0; mem_stall=0 so the pipeline advances exactly once.
  - mem_rdata=rdata_q.
  - Next state IDLE unconditionally.
- Latency: minimum memory op is 3 cycles (IDLE, ACCESS with same-cycle dhit, DONE). Non-memory ops take 1 cycle.
- mem_rdata outside DONE: equals rdata_q from the last completion; MEM/WB samples it only on the DONE cycle.
- Link check: link_valid && link_addr[WORD_W-1:BLK_OFF_BITS] == ex_addr[WORD_W-1:BLK_OFF_BITS].
- Link update priority, highest first:
  1. Halt: clear the link.
  2. snoop_inv whose block matches link_addr: clear the link. This wins over a same-cycle LL completion, so SC fails conservatively.
  3. LL dhit: link_valid=1, link_addr=ex_addr.
  4. SC completion (pass or fail): clear the link.
  5. SW dhit to the linked block: clear the link.
- snoop_inv to a different block leaves the link unchanged.
- SC evaluation:
  - Evaluated in IDLE.
  - A snoop that invalidates the link while the SC is in ACCESS does not abort the write. The cache coherence protocol orders it.
- Halt:
  - ex_valid & ex_halt in IDLE sets halt_o=1, sticky until reset.
  - No memory request is issued for a halt.
- ex_valid=0 in IDLE: no request, no stall, no link change except by snoop.
- Reset asserted mid-ACCESS: requests drop immediately (async); state returns to IDLE.

Decomposition:
- cpu_types_pkg: add memstate_t enum {IDLE, ACCESS, DONE}; reuse word_t.
- BLK_OFF_BITS default mirrors the dcache block constant in the package.
- One natural sub-module, llsc_link_reg:
  - Holds link_valid and link_addr.
  - Implements the priority update list above.
  - Exposes a combinational link_match(addr) output.
- The FSM and request drive remain in mem_stage_ctrl.

Test Plan:
- LW addr 0x100, dhit after 2 wait cycles, dmemload=0xDEADBEEF -> mem_stall high 4 cycles, dmemREN high 3 cycles, DONE cycle mem_rdata=0xDEADBEEF, stall low.
- LL 0x200 then SC 0x204 (same block), data 0x5 -> SC issues dmemWEN with dmemstore=0x5, mem_rdata=1, link_valid=0 after.
- LL 0x200, snoop_inv 0x200, then SC 0x200 -> no dmemWEN ever asserted, mem_rdata=0, 2-cycle SC.
- LL 0x200 with snoop_inv 0x200 on the same dhit cycle -> link_valid=0; following SC fails (mem_rdata=0).
- ALU op (ex_valid=1, no DRen/DWen) back-to-back with bubble -> mem_stall=0 throughout, no requests; then HALT -> halt_o=1 and stays 1 across later inputs.
- nRST pulled low while in ACCESS with dmemWEN=1 -> dmemWEN=0 same cycle, state IDLE, halt_o=0, link_valid=0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: word type, dcache block geometry and the
// memory-stage controller state encoding.
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  // Low address bits that select a word inside a dcache block.
  localparam int DCACHE_BLK_OFF_BITS = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } memstate_t;

endpackage

// File: rtl/llsc_link_reg.sv
// LL/SC link register: remembers the block reserved by the last LL and
// drops the reservation on halt, snoop invalidate, SC completion or a
// plain store to the reserved block.
module llsc_link_reg #(
  parameter int BLK_W = 29
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             halt_clr,
  input  logic             snoop_inv,
  input  logic [BLK_W-1:0] snoop_blk,
  input  logic             ll_set,
  input  logic             sc_done,
  input  logic             sw_done,
  input  logic [BLK_W-1:0] op_blk,
  output logic             link_match
);

  logic             link_valid_r;
  logic [BLK_W-1:0] link_blk_r;
  logic [BLK_W-1:0] snoop_tgt_s;
  logic             snoop_hit_s;

  // Block compare for SC/SW, and snoop compare against the block the link
  // will hold after this cycle (a same-cycle LL block counts, so SC fails).
  always_comb begin
    link_match  = link_valid_r && (link_blk_r == op_blk);
    snoop_tgt_s = ll_set ? op_blk : link_blk_r;
    snoop_hit_s = snoop_inv && (snoop_tgt_s == snoop_blk);
  end

  // Prioritised link update: halt, snoop, LL set, SC done, SW to linked block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      link_valid_r <= 1'b0;
      link_blk_r   <= {BLK_W{1'b0}};
    end else if (halt_clr) begin
      link_valid_r <= 1'b0;
    end else if (snoop_hit_s) begin
      link_valid_r <= 1'b0;
    end else if (ll_set) begin
      link_valid_r <= 1'b1;
      link_blk_r   <= op_blk;
    end else if (sc_done) begin
      link_valid_r <= 1'b0;
    end else if (sw_done && link_match) begin
      link_valid_r <= 1'b0;
    end else begin
      link_valid_r <= link_valid_r;
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: issues dcache requests from the EX/MEM latch,
// stalls the pipeline until dhit, evaluates SC against the LL link and
// returns load / SC result data for MEM/WB. Halt is sticky until reset.
module mem_stage_ctrl
  import cpu_types_pkg::*;
#(
  parameter int BLK_OFF_BITS = DCACHE_BLK_OFF_BITS,
  parameter int WORD_W       = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ex_valid,
  input  logic              ex_DRen,
  input  logic              ex_DWen,
  input  logic              ex_LL,
  input  logic              ex_SC,
  input  logic              ex_halt,
  input  logic [WORD_W-1:0] ex_addr,
  input  logic [WORD_W-1:0] ex_store,
  input  logic              dhit,
  input  logic [WORD_W-1:0] dmemload,
  input  logic              snoop_inv,
  input  logic [WORD_W-1:0] snoop_addr,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [WORD_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] dmemstore,
  output logic              mem_stall,
  output logic [WORD_W-1:0] mem_rdata,
  output logic              halt_o
);

  localparam int BLK_W = WORD_W - BLK_OFF_BITS;

  memstate_t         state_r;
  logic              ren_r;
  logic              wen_r;
  logic [WORD_W-1:0] addr_r;
  logic [WORD_W-1:0] store_r;
  logic [WORD_W-1:0] rdata_q_r;
  logic              halt_r;

  logic              mem_op_s;
  logic              halt_req_s;
  logic              link_match_s;
  logic              sc_fail_s;
  logic              hit_s;
  logic              ll_set_s;
  logic              sc_done_s;
  logic              sw_done_s;
  logic              mem_stall_s;
  logic              snoop_off_unused_s;

  // Word offset of a snoop is irrelevant: invalidation is per block.
  assign snoop_off_unused_s = ^snoop_addr[BLK_OFF_BITS-1:0];

  // Decode of the current EX/MEM instruction against the FSM state.
  always_comb begin
    halt_req_s = (state_r == IDLE) && ex_valid && ex_halt;
    mem_op_s   = ex_valid && !ex_halt && (ex_DRen || ex_DWen);
    sc_fail_s  = (state_r == IDLE) && mem_op_s && ex_SC && !link_match_s;
    hit_s      = (state_r == ACCESS) && dhit;
    ll_set_s   = hit_s && ex_LL;
    sc_done_s  = sc_fail_s || (hit_s && ex_SC);
    sw_done_s  = hit_s && ex_DWen && !ex_SC;
    case (state_r)
      IDLE:    mem_stall_s = mem_op_s;
      ACCESS:  mem_stall_s = 1'b1;
      DONE:    mem_stall_s = 1'b0;
      default: mem_stall_s = 1'b0;
    endcase
  end

  llsc_link_reg #(
    .BLK_W(BLK_W)
  ) u_link (
    .clk       (CLK),
    .rst_n     (nRST),
    .halt_clr  (halt_req_s),
    .snoop_inv (snoop_inv),
    .snoop_blk (snoop_addr[WORD_W-1:BLK_OFF_BITS]),
    .ll_set    (ll_set_s),
    .sc_done   (sc_done_s),
    .sw_done   (sw_done_s),
    .op_blk    (ex_addr[WORD_W-1:BLK_OFF_BITS]),
    .link_match(link_match_s)
  );

  // Memory FSM with registered request drive, result capture and sticky halt.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r   <= IDLE;
      ren_r     <= 1'b0;
      wen_r     <= 1'b0;
      addr_r    <= {WORD_W{1'b0}};
      store_r   <= {WORD_W{1'b0}};
      rdata_q_r <= {WORD_W{1'b0}};
      halt_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (halt_req_s) begin
            halt_r <= 1'b1;
          end
          if (sc_fail_s) begin
            rdata_q_r <= {WORD_W{1'b0}};
            state_r   <= DONE;
          end else if (mem_op_s) begin
            ren_r   <= ex_DRen;
            wen_r   <= ex_DWen;
            addr_r  <= ex_addr;
            store_r <= ex_store;
            state_r <= ACCESS;
          end else begin
            state_r <= IDLE;
          end
        end
        ACCESS: begin
          if (dhit) begin
            ren_r   <= 1'b0;
            wen_r   <= 1'b0;
            addr_r  <= {WORD_W{1'b0}};
            store_r <= {WORD_W{1'b0}};
            if (ex_DRen) begin
              rdata_q_r <= dmemload;
            end else if (ex_SC) begin
              rdata_q_r <= {{(WORD_W-1){1'b0}}, 1'b1};
            end
            state_r <= DONE;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign dmemREN   = ren_r;
  assign dmemWEN   = wen_r;
  assign dmemaddr  = addr_r;
  assign dmemstore = store_r;
  assign mem_stall = mem_stall_s;
  assign mem_rdata = rdata_q_r;
  assign halt_o    = halt_r;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: the driver pushes expected completions
// into a queue, an independent monitor pops and compares them whenever a
// stalled operation completes (first non-stall cycle after stalls).
module tb_mem_stage_ctrl;

  logic        CLK;
  logic        nRST;
  logic        ex_valid, ex_DRen, ex_DWen, ex_LL, ex_SC, ex_halt;
  logic [31:0] ex_addr, ex_store;
  logic        dhit;
  logic [31:0] dmemload;
  logic        snoop_inv;
  logic [31:0] snoop_addr;
  logic        dmemREN, dmemWEN;
  logic [31:0] dmemaddr, dmemstore;
  logic        mem_stall;
  logic [31:0] mem_rdata;
  logic        halt_o;

  mem_stage_ctrl dut (
    .CLK(CLK), .nRST(nRST),
    .ex_valid(ex_valid), .ex_DRen(ex_DRen), .ex_DWen(ex_DWen),
    .ex_LL(ex_LL), .ex_SC(ex_SC), .ex_halt(ex_halt),
    .ex_addr(ex_addr), .ex_store(ex_store),
    .dhit(dhit), .dmemload(dmemload),
    .snoop_inv(snoop_inv), .snoop_addr(snoop_addr),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .mem_stall(mem_stall), .mem_rdata(mem_rdata), .halt_o(halt_o)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] rdata;
    logic [7:0]  stall;
    logic [7:0]  ren;
    logic [7:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", n, act, req);
    end
  endtask

  task automatic expect_op(input string n, input logic [31:0] rd, input int st,
                           input int rn, input int wn, input logic [31:0] a,
                           input logic [31:0] wd);
    exp_t e;
    e.rdata = rd;
    e.stall = 8'(st);
    e.ren   = 8'(rn);
    e.wen   = 8'(wn);
    e.addr  = a;
    e.wdata = wd;
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  task automatic set_bubble();
    ex_valid = 1'b0; ex_DRen = 1'b0; ex_DWen = 1'b0;
    ex_LL = 1'b0; ex_SC = 1'b0; ex_halt = 1'b0;
    ex_addr = 32'h0; ex_store = 32'h0;
  endtask

  // Memory op: holds the instruction until its non-stall cycle, answering the
  // request with dhit after waitn request cycles (optional same-cycle snoop).
  task automatic run_op(input string n, input logic dr, input logic dw, input logic ll,
                        input logic sc, input logic [31:0] a, input logic [31:0] st,
                        input int waitn, input logic [31:0] ld, input logic snp,
                        input logic [31:0] saddr);
    int cnt;
    logic done;
    ex_valid = 1'b1; ex_DRen = dr; ex_DWen = dw; ex_LL = ll; ex_SC = sc;
    ex_halt = 1'b0; ex_addr = a; ex_store = st;
    cnt = 0;
    done = 1'b0;
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      @(negedge CLK);
      dhit = 1'b0;
      snoop_inv = 1'b0;
      if (dmemREN || dmemWEN) begin
        if (cnt == waitn) begin
          dhit = 1'b1;
          dmemload = ld;
          if (snp) begin
            snoop_inv = 1'b1;
            snoop_addr = saddr;
          end
        end
        cnt++;
      end
      if (!mem_stall) done = 1'b1;
      @(posedge CLK); #1;
    end
    dhit = 1'b0;
    snoop_inv = 1'b0;
    set_bubble();
    chk({n, ".finished"}, 32'(done), 32'd1);
  endtask

  // Non-memory slot (ALU op, bubble or halt): must not stall or request.
  task automatic run_alu(input string n, input logic v, input logic h,
                         input logic snp, input logic [31:0] saddr);
    ex_valid = v; ex_halt = h;
    snoop_inv = snp; snoop_addr = saddr;
    @(negedge CLK);
    chk({n, ".stall"}, 32'(mem_stall), 32'd0);
    chk({n, ".req"}, 32'({dmemREN, dmemWEN}), 32'd0);
    @(posedge CLK); #1;
    snoop_inv = 1'b0;
    set_bubble();
  endtask

  int          stall_cnt, ren_cnt, wen_cnt;
  logic [31:0] addr_seen, wdata_seen;

  // Monitor: accumulates per-operation activity and scores each completion.
  always @(negedge CLK) begin
    exp_t  e;
    string n;
    if (!nRST) begin
      stall_cnt = 0; ren_cnt = 0; wen_cnt = 0;
      addr_seen = 32'h0; wdata_seen = 32'h0;
    end else begin
      if (mem_stall) stall_cnt++;
      if (dmemREN) begin ren_cnt++; addr_seen = dmemaddr; end
      if (dmemWEN) begin wen_cnt++; addr_seen = dmemaddr; wdata_seen = dmemstore; end
      if (!mem_stall && stall_cnt > 0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_completion: got a completion, expected none");
        end else begin
          e = exp_q.pop_front();
          n = name_q.pop_front();
          chk({n, ".rdata"}, mem_rdata, e.rdata);
          chk({n, ".stall_cycles"}, 32'(stall_cnt), {24'd0, e.stall});
          chk({n, ".ren_cycles"}, 32'(ren_cnt), {24'd0, e.ren});
          chk({n, ".wen_cycles"}, 32'(wen_cnt), {24'd0, e.wen});
          if (e.ren != 8'd0 || e.wen != 8'd0) chk({n, ".addr"}, addr_seen, e.addr);
          if (e.wen != 8'd0) chk({n, ".wdata"}, wdata_seen, e.wdata);
        end
        stall_cnt = 0; ren_cnt = 0; wen_cnt = 0;
        addr_seen = 32'h0; wdata_seen = 32'h0;
      end
    end
  end

  initial begin
    logic found;
    nRST = 1'b0;
    set_bubble();
    dhit = 1'b0; dmemload = 32'h0; snoop_inv = 1'b0; snoop_addr = 32'h0;
    #3;
    chk("reset.req", 32'({dmemREN, dmemWEN}), 32'd0);
    chk("reset.addr", dmemaddr, 32'h0);
    chk("reset.store", dmemstore, 32'h0);
    chk("reset.stall", 32'(mem_stall), 32'd0);
    chk("reset.rdata", mem_rdata, 32'h0);
    chk("reset.halt", 32'(halt_o), 32'd0);
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;
    @(posedge CLK); #1;

    // LW with two wait cycles.
    expect_op("lw", 32'hDEADBEEF, 4, 3, 0, 32'h100, 32'h0);
    run_op("lw", 1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0, 2, 32'hDEADBEEF, 1'b0, 32'h0);

    // LL then SC to the same block passes; a second SC then fails.
    expect_op("ll1", 32'h11111111, 2, 1, 0, 32'h200, 32'h0);
    run_op("ll1", 1'b1, 1'b0, 1'b1, 1'b0, 32'h200, 32'h0, 0, 32'h11111111, 1'b0, 32'h0);
    expect_op("sc1", 32'h1, 3, 0, 2, 32'h204, 32'h5);
    run_op("sc1", 1'b0, 1'b1, 1'b0, 1'b1, 32'h204, 32'h5, 1, 32'h0, 1'b0, 32'h0);
    expect_op("sc1_again", 32'h0, 1, 0, 0, 32'h0, 32'h0);
    run_op("sc1_again", 1'b0, 1'b1, 1'b0, 1'b1, 32'h204, 32'h6, 0, 32'h0, 1'b0, 32'h0);

    // Snoop between LL and SC kills the link.
    expect_op("ll2", 32'h22222222, 2, 1, 0, 32'h200, 32'h0);
    run_op("ll2", 1'b1, 1'b0, 1'b1, 1'b0, 32'h200, 32'h0, 0, 32'h22222222, 1'b0, 32'h0);
    run_alu("snoop2", 1'b0, 1'b0, 1'b1, 32'h200);
    expect_op("sc2", 32'h0, 1, 0, 0, 32'h0, 32'h0);
    run_op("sc2", 1'b0, 1'b1, 1'b0, 1'b1, 32'h200, 32'h7, 0, 32'h0, 1'b0, 32'h0);

    // Snoop on the LL dhit cycle wins over the link set.
    expect_op("ll3", 32'h33333333, 2, 1, 0, 32'h200, 32'h0);
    run_op("ll3", 1'b1, 1'b0, 1'b1, 1'b0, 32'h200, 32'h0, 0, 32'h33333333, 1'b1, 32'h200);
    expect_op("sc3", 32'h0, 1, 0, 0, 32'h0, 32'h0);
    run_op("sc3", 1'b0, 1'b1, 1'b0, 1'b1, 32'h200, 32'h8, 0, 32'h0, 1'b0, 32'h0);

    // Snoop to the neighbouring block leaves the link intact.
    expect_op("ll4", 32'h44444444, 2, 1, 0, 32'h300, 32'h0);
    run_op("ll4", 1'b1, 1'b0, 1'b1, 1'b0, 32'h300, 32'h0, 0, 32'h44444444, 1'b0, 32'h0);
    run_alu("snoop4", 1'b0, 1'b0, 1'b1, 32'h308);
    expect_op("sc4", 32'h1, 2, 0, 1, 32'h304, 32'h9);
    run_op("sc4", 1'b0, 1'b1, 1'b0, 1'b1, 32'h304, 32'h9, 0, 32'h0, 1'b0, 32'h0);

    // Plain SW to the linked block clears the link; SW keeps old rdata.
    expect_op("ll5", 32'h55555555, 2, 1, 0, 32'h400, 32'h0);
    run_op("ll5", 1'b1, 1'b0, 1'b1, 1'b0, 32'h400, 32'h0, 0, 32'h55555555, 1'b0, 32'h0);
    expect_op("sw5", 32'h55555555, 2, 0, 1, 32'h404, 32'h7);
    run_op("sw5", 1'b0, 1'b1, 1'b0, 1'b0, 32'h404, 32'h7, 0, 32'h0, 1'b0, 32'h0);
    expect_op("sc5", 32'h0, 1, 0, 0, 32'h0, 32'h0);
    run_op("sc5", 1'b0, 1'b1, 1'b0, 1'b1, 32'h400, 32'hA, 0, 32'h0, 1'b0, 32'h0);

    // ALU ops and bubbles never stall; HALT is sticky and clears the link.
    expect_op("ll6", 32'h66666666, 2, 1, 0, 32'h500, 32'h0);
    run_op("ll6", 1'b1, 1'b0, 1'b1, 1'b0, 32'h500, 32'h0, 0, 32'h66666666, 1'b0, 32'h0);
    run_alu("alu_a", 1'b1, 1'b0, 1'b0, 32'h0);
    run_alu("alu_b", 1'b1, 1'b0, 1'b0, 32'h0);
    run_alu("bubble", 1'b0, 1'b0, 1'b0, 32'h0);
    run_alu("alu_c", 1'b1, 1'b0, 1'b0, 32'h0);
    chk("halt.before", 32'(halt_o), 32'd0);
    run_alu("halt", 1'b1, 1'b1, 1'b0, 32'h0);
    chk("halt.set", 32'(halt_o), 32'd1);
    run_alu("alu_d", 1'b1, 1'b0, 1'b0, 32'h0);
    run_alu("bubble2", 1'b0, 1'b0, 1'b0, 32'h0);
    chk("halt.sticky", 32'(halt_o), 32'd1);
    expect_op("sc6", 32'h0, 1, 0, 0, 32'h0, 32'h0);
    run_op("sc6", 1'b0, 1'b1, 1'b0, 1'b1, 32'h500, 32'hB, 0, 32'h0, 1'b0, 32'h0);
    chk("halt.sticky2", 32'(halt_o), 32'd1);

    // Reset in the middle of a write access.
    expect_op("ll7", 32'h77777777, 2, 1, 0, 32'h600, 32'h0);
    run_op("ll7", 1'b1, 1'b0, 1'b1, 1'b0, 32'h600, 32'h0, 0, 32'h77777777, 1'b0, 32'h0);
    ex_valid = 1'b1; ex_DWen = 1'b1; ex_addr = 32'h600; ex_store = 32'hAB;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge CLK);
      if (dmemWEN) found = 1'b1;
    end
    chk("rst_mid.wen_seen", 32'(found), 32'd1);
    #2 nRST = 1'b0;
    set_bubble();
    #1;
    chk("rst_mid.req", 32'({dmemREN, dmemWEN}), 32'd0);
    chk("rst_mid.stall", 32'(mem_stall), 32'd0);
    chk("rst_mid.halt", 32'(halt_o), 32'd0);
    chk("rst_mid.rdata", mem_rdata, 32'h0);
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;
    @(posedge CLK); #1;
    expect_op("sc7", 32'h0, 1, 0, 0, 32'h0, 32'h0);
    run_op("sc7", 1'b0, 1'b1, 1'b0, 1'b1, 32'h600, 32'hC, 0, 32'h0, 1'b0, 32'h0);

    repeat (2) @(posedge CLK);
    chk("scoreboard.drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
